// File: rtl/mem_stage_pkg.sv
// Shared pipeline definitions for the EX/MEM and MEM/WB bundles.
// The memory stage and the stages around it slice their bundles with these constants.
package mem_stage_pkg;

   localparam int EXMEM_W          = 24;
   localparam int EXMEM_ALU_LSB    = 0;
   localparam int EXMEM_ALU_MSB    = 7;
   localparam int EXMEM_STDATA_LSB = 8;
   localparam int EXMEM_STDATA_MSB = 15;
   localparam int EXMEM_RD_LSB     = 16;
   localparam int EXMEM_RD_MSB     = 19;
   localparam int EXMEM_CTRL_LSB   = 20;
   localparam int EXMEM_CTRL_MSB   = 23;
   localparam int EXMEM_MEM_TO_REG = 20;
   localparam int EXMEM_WR_EN      = 21;
   localparam int EXMEM_RD_EN      = 22;
   localparam int EXMEM_REG_WRITE  = 23;

   localparam int MEMWB_W          = 22;
   localparam int MEMWB_LD_LSB     = 0;
   localparam int MEMWB_LD_MSB     = 7;
   localparam int MEMWB_ALU_LSB    = 8;
   localparam int MEMWB_ALU_MSB    = 15;
   localparam int MEMWB_RD_LSB     = 16;
   localparam int MEMWB_RD_MSB     = 19;
   localparam int MEMWB_MEM_TO_REG = 20;
   localparam int MEMWB_REG_WRITE  = 21;

   // An enable counts only when it is a clean 1; X or Z is treated as 0.
   function automatic logic en_bit(input logic b);
      return (b === 1'b1);
   endfunction

endpackage

// File: rtl/mem_stage_if.sv
// Bundle interface between the EX/MEM register, the memory stage and the MEM/WB register.
interface mem_stage_if;
   logic [mem_stage_pkg::EXMEM_W-1:0] exmem_in;
   logic                              stall;
   logic [mem_stage_pkg::MEMWB_W-1:0] memwb_out;
   logic                              err;

   modport master (output exmem_in, input stall, input memwb_out, input err);
   modport slave  (input exmem_in, output stall, output memwb_out, output err);
endinterface

// File: rtl/mem_stage_data_mem.sv
// DEPTH x 8 data memory: synchronous write, combinational read, contents not reset.
module data_mem #(
   parameter int DEPTH = 256
) (
   input  logic       clk,
   input  logic       we,
   input  logic [7:0] addr,
   input  logic [7:0] wdata,
   output logic [7:0] rdata
);
   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [7:0]    mem [DEPTH];
   logic [AW-1:0] idx;

   assign idx   = addr[AW-1:0];
   assign rdata = mem[idx];

   always_ff @(posedge clk) begin
      if (we) mem[idx] <= wdata;
   end
endmodule

// File: rtl/mem_stage.sv
// Memory-access stage: wait-stated 8-bit load/store against an internal array,
// stalling upstream while busy and registering the MEM/WB bundle.
module mem_stage
   import mem_stage_pkg::*;
#(
   parameter int DEPTH   = 256,
   parameter int MEM_LAT = 2
) (
   input logic        nclk,
   input logic        rst,
   mem_stage_if.slave bus
);
   localparam logic [0:0] IDLE    = 1'b0;
   localparam logic [0:0] BUSY    = 1'b1;
   localparam logic [3:0] LAT_M1  = (MEM_LAT == 0) ? 4'd0 : 4'(MEM_LAT - 1);
   localparam logic [8:0] DEPTH_L = 9'(DEPTH);

   logic [0:0]         state;
   logic [3:0]         cnt;
   logic [7:0]         addr;
   logic [7:0]         st_data;
   logic [7:0]         rdata;
   logic [3:0]         rd_dest;
   logic               rd_en;
   logic               wr_en;
   logic               mem_op;
   logic               in_range;
   logic               stall;
   logic               commit;
   logic               we;
   logic               err_q;
   logic [MEMWB_W-1:0] memwb_nxt;
   logic [MEMWB_W-1:0] memwb_q;

   assign addr     = bus.exmem_in[EXMEM_ALU_MSB:EXMEM_ALU_LSB];
   assign st_data  = bus.exmem_in[EXMEM_STDATA_MSB:EXMEM_STDATA_LSB];
   assign rd_dest  = bus.exmem_in[EXMEM_RD_MSB:EXMEM_RD_LSB];
   assign rd_en    = en_bit(bus.exmem_in[EXMEM_RD_EN]);
   assign wr_en    = en_bit(bus.exmem_in[EXMEM_WR_EN]);
   assign mem_op   = rd_en | wr_en;
   assign in_range = ({1'b0, addr} < DEPTH_L);

   always_comb begin
      stall  = 1'b0;
      commit = 1'b0;
      if (state == IDLE) begin
         if (mem_op) begin
            if (MEM_LAT == 0) commit = 1'b1;
            else              stall  = 1'b1;
         end
      end else begin
         if (cnt != 4'd0) stall  = 1'b1;
         else             commit = 1'b1;
      end
   end

   // Store wins over a simultaneous load; out-of-range and in-reset stores never reach the array.
   assign we = commit & wr_en & in_range & ~rst;

   data_mem #(.DEPTH(DEPTH)) u_data_mem (
      .clk   (nclk),
      .we    (we),
      .addr  (addr),
      .wdata (st_data),
      .rdata (rdata)
   );

   always_comb begin
      memwb_nxt = '0;
      if (!stall) begin
         memwb_nxt[MEMWB_ALU_MSB:MEMWB_ALU_LSB] = addr;
         memwb_nxt[MEMWB_RD_MSB:MEMWB_RD_LSB]   = rd_dest;
         memwb_nxt[MEMWB_MEM_TO_REG]            = bus.exmem_in[EXMEM_MEM_TO_REG];
         memwb_nxt[MEMWB_REG_WRITE]             = bus.exmem_in[EXMEM_REG_WRITE];
         if (commit && rd_en && !wr_en && in_range)
            memwb_nxt[MEMWB_LD_MSB:MEMWB_LD_LSB] = rdata;
      end
   end

   always_ff @(posedge nclk or posedge rst) begin
      if (rst) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         memwb_q <= '0;
         err_q   <= 1'b0;
      end else begin
         memwb_q <= memwb_nxt;
         if (commit && ((rd_en && wr_en) || !in_range)) err_q <= 1'b1;
         if (state == IDLE) begin
            if (mem_op && MEM_LAT != 0) begin
               state <= BUSY;
               cnt   <= LAT_M1;
            end
         end else if (cnt != 4'd0) begin
            cnt <= cnt - 4'd1;
         end else begin
            state <= IDLE;
         end
      end
   end

   assign bus.stall     = stall;
   assign bus.memwb_out = memwb_q;
   assign bus.err       = err_q;
endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: three instances cover MEM_LAT=2, MEM_LAT=0 and DEPTH=16.
module tb_mem_stage;
   logic nclk = 1'b0;
   logic rst  = 1'b1;
   int   total  = 0;
   int   passed = 0;
   int   failed = 0;

   always #5 nclk = ~nclk;

   mem_stage_if bus0();
   mem_stage_if bus1();
   mem_stage_if bus2();

   mem_stage #(.DEPTH(256), .MEM_LAT(2)) u_lat2 (.nclk(nclk), .rst(rst), .bus(bus0));
   mem_stage #(.DEPTH(256), .MEM_LAT(0)) u_lat0 (.nclk(nclk), .rst(rst), .bus(bus1));
   mem_stage #(.DEPTH(16),  .MEM_LAT(2)) u_d16  (.nclk(nclk), .rst(rst), .bus(bus2));

   function automatic logic [23:0] mk(input logic rw, input logic rde, input logic wre,
                                      input logic m2r, input logic [3:0] rdd,
                                      input logic [7:0] sd, input logic [7:0] alu);
      return {rw, rde, wre, m2r, rdd, sd, alu};
   endfunction

   task automatic set_in(input int w, input logic [23:0] v);
      case (w)
         0:       bus0.exmem_in = v;
         1:       bus1.exmem_in = v;
         default: bus2.exmem_in = v;
      endcase
   endtask

   // what: 0 = stall, 1 = memwb_out, 2 = err
   function automatic logic [31:0] peek(input int w, input int what);
      logic [31:0] r;
      r = '0;
      case (w)
         0: r = (what == 0) ? 32'(bus0.stall) : (what == 1) ? 32'(bus0.memwb_out) : 32'(bus0.err);
         1: r = (what == 0) ? 32'(bus1.stall) : (what == 1) ? 32'(bus1.memwb_out) : 32'(bus1.err);
         default: r = (what == 0) ? 32'(bus2.stall) : (what == 1) ? 32'(bus2.memwb_out) : 32'(bus2.err);
      endcase
      return r;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) passed++;
      else begin
         failed++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge nclk);
      #1;
   endtask

   // Present one op, check the stall/bubble pattern, then the committed bundle.
   task automatic run_op(input int w, input int lat, input string tag,
                         input logic [23:0] v, input logic [21:0] exp);
      set_in(w, v);
      #1;
      for (int i = 0; i < lat; i++) begin
         chk({tag, "_stall_hi"}, peek(w, 0), 32'd1);
         step();
         chk({tag, "_bubble"}, peek(w, 1), 32'd0);
      end
      chk({tag, "_stall_lo"}, peek(w, 0), 32'd0);
      step();
      chk({tag, "_memwb"}, peek(w, 1), 32'(exp));
      set_in(w, 24'd0);
      #1;
   endtask

   initial begin
      bus0.exmem_in = '0;
      bus1.exmem_in = '0;
      bus2.exmem_in = '0;
      step();
      step();
      for (int w = 0; w < 3; w++) begin
         chk("rst_stall", peek(w, 0), 32'd0);
         chk("rst_memwb", peek(w, 1), 32'd0);
         chk("rst_err",   peek(w, 2), 32'd0);
      end
      rst = 1'b0;
      step();

      // Seed 0x05, then interrupt a second store to 0x05 with reset
      run_op(0, 2, "seed05", mk(0, 0, 1, 0, 4'd0, 8'h5A, 8'h05), 22'h000500);
      set_in(0, mk(0, 0, 1, 0, 4'd0, 8'hEE, 8'h05));
      #1;
      chk("rstbusy_stall0", peek(0, 0), 32'd1);
      step();
      rst = 1'b1;
      set_in(0, 24'd0);
      #1;
      chk("rstbusy_stall", peek(0, 0), 32'd0);
      chk("rstbusy_memwb", peek(0, 1), 32'd0);
      step();
      rst = 1'b0;
      step();
      run_op(0, 2, "rstbusy_load", mk(1, 1, 0, 1, 4'd5, 8'h00, 8'h05), 22'h35055A);

      // Store then load, MEM_LAT=2
      run_op(0, 2, "st10", mk(0, 0, 1, 0, 4'd0, 8'hA5, 8'h10), 22'h001000);
      run_op(0, 2, "ld10", mk(1, 1, 0, 1, 4'd3, 8'h00, 8'h10), 22'h3310A5);
      chk("err_clean", peek(0, 2), 32'd0);

      // Non-memory op
      run_op(0, 0, "nonmem", mk(1, 0, 0, 0, 4'd7, 8'h00, 8'h3C), 22'h273C00);

      // Both enables: store wins, load data 0, sticky err
      run_op(0, 2, "both", mk(0, 1, 1, 0, 4'd0, 8'h77, 8'h01), 22'h000100);
      chk("both_err", peek(0, 2), 32'd1);
      run_op(0, 2, "both_ld", mk(1, 1, 0, 1, 4'd1, 8'h00, 8'h01), 22'h310177);
      run_op(0, 0, "both_idle", mk(0, 0, 0, 0, 4'd0, 8'h00, 8'h00), 22'h000000);
      chk("both_err_held", peek(0, 2), 32'd1);

      // MEM_LAT=0 back-to-back store and load
      run_op(1, 0, "l0_st", mk(0, 0, 1, 0, 4'd0, 8'h11, 8'h20), 22'h002000);
      set_in(1, mk(1, 1, 0, 1, 4'd4, 8'h00, 8'h20));
      #1;
      chk("l0_ld_stall", peek(1, 0), 32'd0);
      step();
      chk("l0_ld_memwb", peek(1, 1), 32'h342011);
      set_in(1, 24'd0);
      chk("l0_err", peek(1, 2), 32'd0);

      // DEPTH=16: out-of-range store must not alias onto 0x00
      run_op(2, 2, "d16_st00", mk(0, 0, 1, 0, 4'd0, 8'h42, 8'h00), 22'h000000);
      chk("d16_err_clean", peek(2, 2), 32'd0);
      run_op(2, 2, "d16_st20", mk(0, 0, 1, 0, 4'd0, 8'h99, 8'h20), 22'h002000);
      chk("d16_err", peek(2, 2), 32'd1);
      run_op(2, 2, "d16_ld20", mk(1, 1, 0, 1, 4'd2, 8'h00, 8'h20), 22'h322000);
      run_op(2, 2, "d16_ld00", mk(1, 1, 0, 1, 4'd2, 8'h00, 8'h00), 22'h320042);

      // Only reset clears err
      rst = 1'b1;
      #1;
      chk("err_clr_lat2", peek(0, 2), 32'd0);
      chk("err_clr_d16",  peek(2, 2), 32'd0);
      step();
      rst = 1'b0;
      step();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end
endmodule
